// File: rtl/weapon_arsenal_ctrl_if.sv
// ---------------------------------------------------------------------------
// weapon_arsenal_ctrl_if
//
// Groups the player-weapon control inputs and the HUD/weapon status outputs
// of weapon_arsenal_ctrl into one bundle.
//
//   in_switch       raw trigger, asynchronous, active-low (0 = pulled)
//   auto_mode       1 = keep re-firing while the trigger is held
//   next_weapon     single-cycle request to select the next weapon
//   ammo_add_valid  ammo pickup strobe
//   ammo_add_idx    weapon receiving the pickup
//   ammo_add_amt    pickup amount
//   weapon_state    one-hot controller state
//   fire_pulse      high exactly while firing
//   dry_fire        one-cycle pulse on a trigger pull with zero ammo
//   weapon_sel      current weapon index
//   ammo            ammo of the current weapon
//
// master: the game logic driving the controller. slave: the controller.
// ---------------------------------------------------------------------------
interface weapon_arsenal_ctrl_if #(
    parameter int NUM_W  = 4,
    parameter int AMMO_W = 8
);
    localparam int SEL_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

    logic              in_switch;
    logic              auto_mode;
    logic              next_weapon;
    logic              ammo_add_valid;
    logic [SEL_W-1:0]  ammo_add_idx;
    logic [AMMO_W-1:0] ammo_add_amt;
    logic [4:0]        weapon_state;
    logic              fire_pulse;
    logic              dry_fire;
    logic [SEL_W-1:0]  weapon_sel;
    logic [AMMO_W-1:0] ammo;

    modport master (
        output in_switch, auto_mode, next_weapon,
               ammo_add_valid, ammo_add_idx, ammo_add_amt,
        input  weapon_state, fire_pulse, dry_fire, weapon_sel, ammo
    );

    modport slave (
        input  in_switch, auto_mode, next_weapon,
               ammo_add_valid, ammo_add_idx, ammo_add_amt,
        output weapon_state, fire_pulse, dry_fire, weapon_sel, ammo
    );
endinterface

// File: rtl/weapon_arsenal_ctrl.sv
// ---------------------------------------------------------------------------
// weapon_arsenal_ctrl
//
// Multi-weapon trigger controller. Synchronises and debounces the raw
// trigger, sequences LOADED / FIRING / COOLDOWN / FIRE_IDLE / SWITCHING,
// and keeps a saturating ammo counter per weapon.
//
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset
//   bus  weapon_arsenal_ctrl_if.slave: trigger, auto mode, weapon switch
//        request and ammo pickup in; one-hot state, fire/dry-fire pulses,
//        selected weapon and its ammo out.
// ---------------------------------------------------------------------------
module weapon_arsenal_ctrl #(
    parameter int NUM_W      = 4,
    parameter int AMMO_W     = 8,
    parameter int MAX_AMMO   = 99,
    parameter int START_AMMO = 20,
    parameter int COOLDOWN   = 4,
    parameter int SWITCH_CYC = 8,
    parameter int DB_CYC     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    weapon_arsenal_ctrl_if.slave  bus
);
    localparam int SEL_W   = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam int CNT_MAX = (COOLDOWN > SWITCH_CYC) ? COOLDOWN : SWITCH_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DB_W    = $clog2(DB_CYC + 1);

    localparam logic [CNT_W-1:0]  COOL_LOAD = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0]  SW_LOAD   = CNT_W'(SWITCH_CYC - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [AMMO_W:0]   MAX_EXT   = (AMMO_W + 1)'(MAX_AMMO);
    localparam logic [AMMO_W-1:0] START_VAL = AMMO_W'(START_AMMO);
    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_W - 1);

    typedef enum logic [4:0] {
        ST_LOADED    = 5'b00001,
        ST_FIRING    = 5'b00010,
        ST_COOLDOWN  = 5'b00100,
        ST_FIRE_IDLE = 5'b01000,
        ST_SWITCHING = 5'b10000
    } state_e;

    // Trigger synchroniser and debouncer
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             trig_db_q, trig_db_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;

    // Sequencer
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             fire_pulse_q, fire_pulse_d;
    logic             dry_fire_q, dry_fire_d;

    // Ammo store
    logic [AMMO_W-1:0] ammo_q [NUM_W];
    logic [AMMO_W-1:0] ammo_d [NUM_W];
    logic [AMMO_W:0]   ammo_sum;

    logic              pressed;
    logic              has_ammo;
    logic              fire_dec;
    logic [AMMO_W-1:0] cur_ammo;

    assign pressed  = !trig_db_q;
    assign cur_ammo = ammo_q[sel_q];
    assign has_ammo = (cur_ammo != '0);

    // Debounce: the filtered value follows the synchronised trigger only
    // after DB_CYC consecutive disagreeing edges; any agreement restarts.
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        sync1_d   = bus.in_switch;
        sync2_d   = sync1_q;
        trig_db_d = trig_db_q;
        db_cnt_d  = '0;
        if (sync2_q != trig_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                trig_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Sequencer next state. cnt is shared by COOLDOWN and SWITCHING; it is
    // loaded with length-1 on entry and the exit decision is taken at zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        fire_dec   = 1'b0;
        dry_fire_d = 1'b0;
        unique case (state_q)
            ST_LOADED: begin
                // A trigger press outranks a weapon-switch request.
                if (pressed) begin
                    if (has_ammo) begin
                        state_d  = ST_FIRING;
                        fire_dec = 1'b1;
                    end else begin
                        state_d    = ST_FIRE_IDLE;
                        dry_fire_d = 1'b1;
                    end
                end else if (bus.next_weapon) begin
                    state_d = ST_SWITCHING;
                    cnt_d   = SW_LOAD;
                    sel_d   = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
                end
            end
            ST_FIRING: begin
                state_d = ST_COOLDOWN;
                cnt_d   = COOL_LOAD;
            end
            ST_COOLDOWN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (bus.auto_mode && pressed && has_ammo) begin
                    state_d  = ST_FIRING;
                    fire_dec = 1'b1;
                end else if (pressed) begin
                    state_d = ST_FIRE_IDLE;
                end else begin
                    state_d = ST_LOADED;
                end
            end
            ST_FIRE_IDLE: begin
                // Semi-auto gate: wait for a release before re-arming.
                if (!pressed) begin
                    state_d = ST_LOADED;
                end
            end
            ST_SWITCHING: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_LOADED;
                end
            end
            default: begin
                state_d = ST_LOADED;
                cnt_d   = '0;
            end
        endcase
        fire_pulse_d = (state_d == ST_FIRING);
    end

    // Ammo update at AMMO_W+1 bits so a pickup cannot wrap before the
    // saturation compare. A shot only happens with ammo > 0, so the
    // decrement never underflows. Out-of-range pickup indices match no entry.
    always_comb begin
        ammo_sum = '0;
        for (int i = 0; i < NUM_W; i++) begin
            ammo_sum = {1'b0, ammo_q[i]};
            if (fire_dec && (sel_q == SEL_W'(i))) begin
                ammo_sum = ammo_sum - (AMMO_W + 1)'(1);
            end
            if (bus.ammo_add_valid && (bus.ammo_add_idx == SEL_W'(i))) begin
                ammo_sum = ammo_sum + {1'b0, bus.ammo_add_amt};
            end
            ammo_d[i] = (ammo_sum > MAX_EXT) ? MAX_EXT[AMMO_W-1:0]
                                             : ammo_sum[AMMO_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            trig_db_q    <= 1'b1;
            db_cnt_q     <= '0;
            state_q      <= ST_LOADED;
            cnt_q        <= '0;
            sel_q        <= '0;
            fire_pulse_q <= 1'b0;
            dry_fire_q   <= 1'b0;
            // NOTE: the ammo array is a small register file whose reset value
            // is game-visible, so every entry is reset, unlike a RAM.
            for (int i = 0; i < NUM_W; i++) begin
                ammo_q[i] <= START_VAL;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            trig_db_q    <= trig_db_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            fire_pulse_q <= fire_pulse_d;
            dry_fire_q   <= dry_fire_d;
            ammo_q       <= ammo_d;
        end
    end

    assign bus.weapon_state = state_q;
    assign bus.fire_pulse   = fire_pulse_q;
    assign bus.dry_fire     = dry_fire_q;
    assign bus.weapon_sel   = sel_q;
    assign bus.ammo         = cur_ammo;

endmodule

// File: tb/tb_weapon_arsenal_ctrl.sv
// ---------------------------------------------------------------------------
// tb_weapon_arsenal_ctrl
//
// Directed bench for weapon_arsenal_ctrl: a default 4-weapon build and a
// 3-weapon build used for out-of-range pickups and selector wrap. Inputs
// change 1 time unit after a rising edge; outputs are read at that point.
// ---------------------------------------------------------------------------
module tb_weapon_arsenal_ctrl;
    localparam logic [4:0] S_LOADED    = 5'b00001;
    localparam logic [4:0] S_FIRING    = 5'b00010;
    localparam logic [4:0] S_COOLDOWN  = 5'b00100;
    localparam logic [4:0] S_FIRE_IDLE = 5'b01000;
    localparam logic [4:0] S_SWITCHING = 5'b10000;

    logic clk;
    logic rst;

    int n_asserts = 0;
    int n_fail    = 0;
    int pulses    = 0;
    int drys      = 0;
    int p0;
    int d0;

    weapon_arsenal_ctrl_if #(.NUM_W(4), .AMMO_W(8)) bus  ();
    weapon_arsenal_ctrl_if #(.NUM_W(3), .AMMO_W(8)) bus3 ();

    weapon_arsenal_ctrl #(.NUM_W(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    weapon_arsenal_ctrl #(.NUM_W(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.fire_pulse) pulses++;
            if (bus.dry_fire)   drys++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_switch = 1'b1;  bus.auto_mode = 1'b0;  bus.next_weapon = 1'b0;
        bus.ammo_add_valid = 1'b0;  bus.ammo_add_idx = '0;  bus.ammo_add_amt = '0;
        bus3.in_switch = 1'b1; bus3.auto_mode = 1'b0; bus3.next_weapon = 1'b0;
        bus3.ammo_add_valid = 1'b0; bus3.ammo_add_idx = '0; bus3.ammo_add_amt = '0;

        // Reset state
        step(2);
        check("rst_state", bus.weapon_state, S_LOADED);
        check("rst_sel",   bus.weapon_sel, 0);
        check("rst_ammo",  bus.ammo, 20);
        check("rst_fire",  bus.fire_pulse, 0);
        check("rst_dry",   bus.dry_fire, 0);
        check("rst_ammo3", bus3.ammo, 20);
        rst = 1'b0;
        step(1);

        // Single semi-auto press: FIRING on the 6th edge after driving low
        p0 = pulses;
        bus.in_switch = 1'b0;
        step(5);
        check("lat_no_fire_yet", bus.fire_pulse, 0);
        check("lat_still_loaded", bus.weapon_state, S_LOADED);
        step(1);
        check("t1_firing", bus.weapon_state, S_FIRING);
        check("t1_pulse",  bus.fire_pulse, 1);
        check("t1_ammo",   bus.ammo, 19);
        step(1);
        check("t1_cool_first", bus.weapon_state, S_COOLDOWN);
        step(3);
        check("t1_cool_last", bus.weapon_state, S_COOLDOWN);
        step(1);
        check("t1_fire_idle", bus.weapon_state, S_FIRE_IDLE);
        check("t1_one_pulse", pulses - p0, 1);
        bus.in_switch = 1'b1;
        step(5);
        check("t1_rel_wait", bus.weapon_state, S_FIRE_IDLE);
        step(1);
        check("t1_rel_loaded", bus.weapon_state, S_LOADED);

        // Glitch of two cycles is rejected
        p0 = pulses;
        bus.in_switch = 1'b0;
        step(2);
        bus.in_switch = 1'b1;
        step(10);
        check("glitch_pulses", pulses - p0, 0);
        check("glitch_state",  bus.weapon_state, S_LOADED);
        check("glitch_ammo",   bus.ammo, 19);

        // Saturating pickup: 19 + 90 -> 99
        bus.ammo_add_valid = 1'b1; bus.ammo_add_idx = 0; bus.ammo_add_amt = 90;
        step(1);
        bus.ammo_add_valid = 1'b0;
        check("pickup_sat", bus.ammo, 99);

        rst = 1'b1;
        step(1);
        check("rst2_ammo", bus.ammo, 20);
        rst = 1'b0;
        step(1);

        // Pickup of 5 on the same edge as a shot at 20 -> 24
        bus.in_switch = 1'b0;
        step(5);
        bus.ammo_add_valid = 1'b1; bus.ammo_add_idx = 0; bus.ammo_add_amt = 5;
        step(1);
        bus.ammo_add_valid = 1'b0;
        check("fire_add_state", bus.weapon_state, S_FIRING);
        check("fire_add_ammo",  bus.ammo, 24);
        bus.in_switch = 1'b1;
        step(12);
        check("fire_add_loaded", bus.weapon_state, S_LOADED);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);

        // Auto mode: 20 shots, 5-cycle period, then FIRE_IDLE at 0 ammo
        p0 = pulses; d0 = drys;
        bus.auto_mode = 1'b1;
        bus.in_switch = 1'b0;
        step(6);
        check("auto_p1",      bus.fire_pulse, 1);
        check("auto_p1_ammo", bus.ammo, 19);
        step(4);
        check("auto_gap", bus.fire_pulse, 0);
        step(1);
        check("auto_p2",      bus.fire_pulse, 1);
        check("auto_p2_ammo", bus.ammo, 18);
        step(100);
        check("auto_end_state", bus.weapon_state, S_FIRE_IDLE);
        check("auto_end_ammo",  bus.ammo, 0);
        check("auto_pulses",    pulses - p0, 20);
        check("auto_no_dry",    drys - d0, 0);

        // Empty weapon: dry fire for one cycle, FIRE_IDLE until release
        bus.auto_mode = 1'b0;
        bus.in_switch = 1'b1;
        step(8);
        check("empty_rearm", bus.weapon_state, S_LOADED);
        p0 = pulses; d0 = drys;
        bus.in_switch = 1'b0;
        step(6);
        check("dry_high",  bus.dry_fire, 1);
        check("dry_state", bus.weapon_state, S_FIRE_IDLE);
        check("dry_nofire", bus.fire_pulse, 0);
        step(1);
        check("dry_low", bus.dry_fire, 0);
        step(10);
        check("dry_held_idle", bus.weapon_state, S_FIRE_IDLE);
        check("dry_pulses", pulses - p0, 0);
        check("dry_count",  drys - d0, 1);
        bus.in_switch = 1'b1;
        step(8);
        check("dry_release", bus.weapon_state, S_LOADED);

        // Weapon switching 1,2,3,0
        bus.next_weapon = 1'b1;
        step(1);
        bus.next_weapon = 1'b0;
        check("sw1_sel",   bus.weapon_sel, 1);
        check("sw1_state", bus.weapon_state, S_SWITCHING);
        step(7);
        check("sw1_still", bus.weapon_state, S_SWITCHING);
        step(1);
        check("sw1_loaded", bus.weapon_state, S_LOADED);
        check("sw1_ammo",   bus.ammo, 20);
        for (int i = 0; i < 3; i++) begin
            bus.next_weapon = 1'b1;
            step(1);
            bus.next_weapon = 1'b0;
            check("sw_seq_sel", bus.weapon_sel, (i == 2) ? 0 : i + 2);
            step(9);
        end
        check("sw_wrap_ammo", bus.ammo, 0);

        // Press and next_weapon together: fire wins; next during COOLDOWN ignored
        bus.next_weapon = 1'b1;
        step(1);
        bus.next_weapon = 1'b0;
        step(9);
        check("pri_pre_sel", bus.weapon_sel, 1);
        bus.in_switch = 1'b0;
        step(5);
        bus.next_weapon = 1'b1;
        step(1);
        bus.next_weapon = 1'b0;
        check("pri_state", bus.weapon_state, S_FIRING);
        check("pri_sel",   bus.weapon_sel, 1);
        check("pri_ammo",  bus.ammo, 19);
        step(2);
        bus.next_weapon = 1'b1;
        step(1);
        bus.next_weapon = 1'b0;
        check("cool_next_state", bus.weapon_state, S_COOLDOWN);
        check("cool_next_sel",   bus.weapon_sel, 1);
        bus.in_switch = 1'b1;
        step(15);
        check("cool_next_noq_state", bus.weapon_state, S_LOADED);
        check("cool_next_noq_sel",   bus.weapon_sel, 1);

        // Reset mid-SWITCHING aborts and restores ammo
        bus.ammo_add_valid = 1'b1; bus.ammo_add_idx = 1; bus.ammo_add_amt = 3;
        step(1);
        bus.ammo_add_valid = 1'b0;
        check("pre_rst_ammo", bus.ammo, 22);
        bus.next_weapon = 1'b1;
        step(1);
        bus.next_weapon = 1'b0;
        check("pre_rst_sw", bus.weapon_state, S_SWITCHING);
        check("pre_rst_sel", bus.weapon_sel, 2);
        step(2);
        rst = 1'b1;
        #1;
        check("rst_sw_sel",   bus.weapon_sel, 0);
        check("rst_sw_state", bus.weapon_state, S_LOADED);
        check("rst_sw_ammo",  bus.ammo, 20);
        step(1);
        rst = 1'b0;
        step(10);
        check("post_rst_state", bus.weapon_state, S_LOADED);
        check("post_rst_sel",   bus.weapon_sel, 0);
        bus.next_weapon = 1'b1;
        step(1);
        bus.next_weapon = 1'b0;
        step(9);
        check("post_rst_w1_sel",  bus.weapon_sel, 1);
        check("post_rst_w1_ammo", bus.ammo, 20);

        // 3-weapon build: out-of-range pickup ignored, selector wraps 2 -> 0
        bus3.ammo_add_valid = 1'b1; bus3.ammo_add_idx = 3; bus3.ammo_add_amt = 5;
        step(1);
        bus3.ammo_add_valid = 1'b0;
        check("n3_oob_ammo", bus3.ammo, 20);
        bus3.ammo_add_valid = 1'b1; bus3.ammo_add_idx = 0; bus3.ammo_add_amt = 5;
        step(1);
        bus3.ammo_add_valid = 1'b0;
        check("n3_inrange_ammo", bus3.ammo, 25);
        for (int i = 0; i < 3; i++) begin
            bus3.next_weapon = 1'b1;
            step(1);
            bus3.next_weapon = 1'b0;
            check("n3_sel", bus3.weapon_sel, (i == 2) ? 0 : i + 1);
            step(9);
        end
        check("n3_back_ammo", bus3.ammo, 25);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end
endmodule
